apb_requester: RTL and testbench
================================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS-phase cycles to wait for pready before aborting.
REQ-002 The block SHALL have port apb.pclk, input (via APB interface), 1 bit, the single clock.
REQ-003 The block SHALL have port apb.preset_n, input (via APB interface), 1 bit, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port apb, APB.requester, DATA_WIDTH 16, the outbound APB bus.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit, the command request.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit, the command accept.
REQ-007 The block SHALL have port cmd_write, input, 1 bit, meaning 1 = write and 0 = read.
REQ-008 The block SHALL have port cmd_addr, input, apb.ADDR_WIDTH bits, the target address.
REQ-009 The block SHALL have port cmd_wdata, input, 16 bits, the write data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit, the response present.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit, the response consumed.
REQ-012 The block SHALL have port rsp_rdata, output, 16 bits, the read data, which is 0 for writes.
REQ-013 The block SHALL have port rsp_err, output, 1 bit, which is set on pslverr or timeout.
REQ-014 The block SHALL have port rsp_timeout, output, 1 bit, which is set when the error was a timeout.
REQ-015 The block SHALL raise a synthesis error if apb.DATA_WIDTH != 16.

Function
REQ-016 The state machine SHALL have states IDLE, SETUP, ACCESS and RESP.
REQ-017 cmd_ready SHALL equal (state == IDLE) and be combinational.
REQ-018 In IDLE, when cmd_valid && cmd_ready, the block SHALL register addr, write and wdata and go to SETUP.
REQ-019 In SETUP, the bus SHALL drive psel=1, penable=0 with registered paddr, pwrite and pwdata, and the state SHALL go to ACCESS unconditionally.
REQ-020 In ACCESS, the bus SHALL drive psel=1 and penable=1, hold address and control stable, and remain in ACCESS while pready=0.
REQ-021 When ACCESS && pready, the block SHALL capture prdata (reads only), capture pslverr into rsp_err with rsp_timeout=0, and go to RESP.
REQ-022 In RESP, rsp_valid=1 and all rsp_* outputs SHALL hold stable until rsp_ready, then the state SHALL go to IDLE.
REQ-023 rsp_ready asserted outside RESP SHALL be ignored.
REQ-024 psel and penable SHALL be 0 in IDLE and RESP.
REQ-025 pstrb SHALL be all-ones for writes and all-zeros for reads.
REQ-026 pprot SHALL be 0.
REQ-027 Latency: from command accepted at cycle N, SETUP SHALL occur at N+1, the first ACCESS at N+2, and rsp_valid SHALL be high at N+3 with zero wait states.
REQ-028 A new command SHALL be accepted no earlier than the cycle after rsp_ready.
REQ-029 A 16-bit wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0.
REQ-030 When the counter reaches TIMEOUT-1 with pready=0, the block SHALL deassert psel and penable next cycle, set rsp_err=1, rsp_timeout=1 and rsp_rdata=0, and go to RESP.
REQ-031 If pready and the timeout coincide in the same cycle, pready SHALL take priority and the transfer SHALL complete normally.
REQ-032 TIMEOUT=0 SHALL disable the timeout, so the block waits indefinitely.
REQ-033 Command inputs SHALL be ignored outside IDLE.

Reset
REQ-034 Asserting preset_n low SHALL asynchronously force IDLE and clear to 0 psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter.
REQ-035 A reset asserted mid-transfer SHALL drop psel and penable immediately with no response generated.
REQ-036 After deassertion of reset, cmd_ready SHALL be 1 in the first cycle.

Structure
REQ-037 The state enum SHALL reside in a shared apb_requester_pkg.
REQ-038 APB interface types SHALL come from the existing APBTypes.sv.
REQ-039 No sub-module is required; the FSM and counter SHALL be a single module.

Verification
REQ-040 Read 0x0010, completer zero-wait, prdata=0x1234 -> rsp_valid at N+3, rsp_rdata=0x1234, rsp_err=0.
REQ-041 Write 0x0002, wdata=0xBEEF, completer with 3 wait states -> pwdata=0xBEEF and pstrb=2'b11 stable throughout ACCESS, rsp_valid at N+6, rsp_rdata=0.
REQ-042 Read 0x0001, completer pslverr=1 -> rsp_err=1, rsp_timeout=0.
REQ-043 TIMEOUT=16, completer never asserts pready -> psel falls after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; also pready on cycle 16 -> normal completion.
REQ-044 rsp_ready held low 10 cycles with cmd_valid=1 -> cmd_ready=0 and rsp_* stable; the next command is accepted the cycle after rsp_ready.
REQ-045 preset_n pulsed low during ACCESS -> psel=0 and penable=0 within the same cycle, and no rsp_valid is generated.

Source files
------------

// File: rtl/apb_requester_pkg.sv
// apb_requester_pkg: FSM state encoding shared by the APB requester and anything that observes it
package apb_requester_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
endpackage

// File: rtl/APBTypes.sv
// APB: AMBA APB bus with requester and completer views
interface APB #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input logic pclk,
    input logic preset_n
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;
    modport requester (
        input  pclk, preset_n, pready, prdata, pslverr,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );
    modport completer (
        input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_requester.sv
// apb_requester: single-outstanding command-to-APB bridge with an ACCESS wait-state timeout
module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int ADDR_WIDTH = 16
) (
    APB.requester                 apb,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout
);
    localparam int DW = apb.DATA_WIDTH;
    localparam int AW = apb.ADDR_WIDTH;
    if (DW != 16) begin : g_dw_check
        $error("apb_requester requires a 16-bit APB data bus");
    end
    if (AW != ADDR_WIDTH) begin : g_aw_check
        $error("apb_requester ADDR_WIDTH must match the APB bus");
    end
    logic [1:0]            state;
    logic [15:0]           wait_cnt;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [15:0]           pwdata;
    logic                  timed_out;
    // TIMEOUT of 0 never matches, so the requester waits on pready forever
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == 16'(TIMEOUT - 1));
    always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
        if (!apb.preset_n) begin
            state       <= IDLE;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            wait_cnt    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    paddr    <= cmd_addr;
                    pwrite   <= cmd_write;
                    pwdata   <= cmd_wdata;
                    wait_cnt <= '0;
                    state    <= SETUP;
                end
                SETUP: state <= ACCESS;
                ACCESS: if (apb.pready) begin
                    rsp_rdata   <= pwrite ? 16'h0 : apb.prdata;
                    rsp_err     <= apb.pslverr;
                    rsp_timeout <= 1'b0;
                    state       <= RESP;
                end else if (timed_out) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                    state       <= RESP;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign cmd_ready   = state == IDLE;
    assign rsp_valid   = state == RESP;
    // psel/penable decode straight from state so an async reset drops them at once
    assign apb.psel    = (state == SETUP) || (state == ACCESS);
    assign apb.penable = state == ACCESS;
    assign apb.paddr   = paddr;
    assign apb.pwrite  = pwrite;
    assign apb.pwdata  = pwdata;
    assign apb.pstrb   = {(DW/8){pwrite}};
    assign apb.pprot   = 3'b000;
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed checks of the APB requester against hand-computed expectations
module tb_apb_requester;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_valid0, cmd_write, rsp_ready;
    logic [15:0] cmd_addr, cmd_wdata;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [15:0] rsp_rdata;
    logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
    logic [15:0] rsp_rdata0;
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    APB #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) apb  (.pclk(clk), .preset_n(rst_n));
    APB #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) apb0 (.pclk(clk), .preset_n(rst_n));
    apb_requester #(.TIMEOUT(16), .ADDR_WIDTH(16)) dut (
        .apb(apb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
    );
    apb_requester #(.TIMEOUT(0), .ADDR_WIDTH(16)) dut0 (
        .apb(apb0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    // present a command for one cycle; returns at the negedge of the SETUP cycle
    task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask
    task automatic ack(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_idle_ready"}, cmd_ready, 1);
        check({tag, "_idle_valid"}, rsp_valid, 0);
        rsp_ready = 1'b0;
    endtask
    initial begin
        cmd_valid = 0; cmd_valid0 = 0; cmd_write = 0; rsp_ready = 0;
        cmd_addr = 0; cmd_wdata = 0;
        apb.pready = 0; apb.prdata = 0; apb.pslverr = 0;
        apb0.pready = 0; apb0.prdata = 0; apb0.pslverr = 0;
        repeat (2) @(negedge clk);
        check("rst_psel", apb.psel, 0);
        check("rst_penable", apb.penable, 0);
        check("rst_paddr", apb.paddr, 0);
        check("rst_pwdata", apb.pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", cmd_ready, 1);
        // zero-wait read
        apb.pready = 1; apb.prdata = 16'h1234;
        start(0, 16'h0010, 16'h0);
        check("rd_setup_psel", apb.psel, 1);
        check("rd_setup_penable", apb.penable, 0);
        check("rd_setup_paddr", apb.paddr, 16'h0010);
        check("rd_setup_pwrite", apb.pwrite, 0);
        check("rd_pstrb", apb.pstrb, 0);
        check("rd_pprot", apb.pprot, 0);
        @(negedge clk);
        check("rd_access_penable", apb.penable, 1);
        check("rd_access_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rdata", rsp_rdata, 16'h1234);
        check("rd_err", rsp_err, 0);
        check("rd_timeout", rsp_timeout, 0);
        check("rd_resp_psel", apb.psel, 0);
        check("rd_resp_cmd_ready", cmd_ready, 0);
        ack("rd");
        // write with three wait states; stray command during the transfer is ignored
        apb.pready = 0;
        start(1, 16'h0002, 16'hBEEF);
        check("wr_setup_pwdata", apb.pwdata, 16'hBEEF);
        check("wr_setup_penable", apb.penable, 0);
        cmd_valid = 1; cmd_addr = 16'h0055; cmd_wdata = 16'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wr_acc_penable", apb.penable, 1);
            check("wr_acc_paddr", apb.paddr, 16'h0002);
            check("wr_acc_pwdata", apb.pwdata, 16'hBEEF);
            check("wr_acc_pstrb", apb.pstrb, 2'b11);
            check("wr_acc_rsp_valid", rsp_valid, 0);
            if (i == 3) begin
                apb.pready = 1;
                cmd_valid = 0;
            end
        end
        @(negedge clk);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rdata", rsp_rdata, 0);
        check("wr_err", rsp_err, 0);
        ack("wr");
        // slave error on a read
        apb.pslverr = 1; apb.prdata = 16'hAAAA;
        start(0, 16'h0001, 16'h0);
        repeat (2) @(negedge clk);
        check("se_rsp_valid", rsp_valid, 1);
        check("se_err", rsp_err, 1);
        check("se_timeout", rsp_timeout, 0);
        ack("se");
        apb.pslverr = 0;
        // timeout after 16 ACCESS cycles without pready
        apb.pready = 0; apb.prdata = 16'h5A5A;
        start(0, 16'h0100, 16'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("to_acc_penable", apb.penable, 1);
        end
        @(negedge clk);
        check("to_psel", apb.psel, 0);
        check("to_penable", apb.penable, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_err", rsp_err, 1);
        check("to_timeout", rsp_timeout, 1);
        check("to_rdata", rsp_rdata, 0);
        ack("to");
        // pready on the 16th ACCESS cycle wins over the timeout
        start(0, 16'h0200, 16'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("tp_acc_penable", apb.penable, 1);
            if (i == 15) apb.pready = 1;
        end
        @(negedge clk);
        check("tp_rsp_valid", rsp_valid, 1);
        check("tp_err", rsp_err, 0);
        check("tp_timeout", rsp_timeout, 0);
        check("tp_rdata", rsp_rdata, 16'h5A5A);
        ack("tp");
        // response back-pressure with a pending command
        apb.prdata = 16'h0777;
        start(0, 16'h0030, 16'h0);
        repeat (2) @(negedge clk);
        check("bp_rsp_valid0", rsp_valid, 1);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0040; cmd_wdata = 16'h1111;
        apb.prdata = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 16'h0777);
            check("bp_psel", apb.psel, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        check("bp_next_ready", cmd_ready, 1);
        check("bp_next_valid", rsp_valid, 0);
        @(negedge clk);
        cmd_valid = 0;
        check("bp_new_psel", apb.psel, 1);
        check("bp_new_penable", apb.penable, 0);
        check("bp_new_paddr", apb.paddr, 16'h0040);
        check("bp_new_pwrite", apb.pwrite, 1);
        @(negedge clk);
        check("bp_new_access", apb.penable, 1);
        @(negedge clk);
        check("bp_new_rsp_valid", rsp_valid, 1);
        check("bp_new_rdata", rsp_rdata, 0);
        @(negedge clk);
        check("bp_new_done", rsp_valid, 0);
        rsp_ready = 0;
        // asynchronous reset during ACCESS
        apb.pready = 0;
        start(1, 16'h0066, 16'hCAFE);
        @(negedge clk);
        check("ar_pre_penable", apb.penable, 1);
        rst_n = 1'b0;
        #1;
        check("ar_psel", apb.psel, 0);
        check("ar_penable", apb.penable, 0);
        check("ar_paddr", apb.paddr, 0);
        check("ar_pwdata", apb.pwdata, 0);
        check("ar_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        apb.pready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ar_no_rsp", rsp_valid, 0);
            check("ar_no_psel", apb.psel, 0);
        end
        // TIMEOUT=0 waits indefinitely
        cmd_valid0 = 1; cmd_write = 0; cmd_addr = 16'h0077;
        @(negedge clk);
        cmd_valid0 = 0;
        repeat (40) @(negedge clk);
        check("t0_psel", apb0.psel, 1);
        check("t0_penable", apb0.penable, 1);
        check("t0_rsp_valid", rsp_valid0, 0);
        apb0.pready = 1; apb0.prdata = 16'h0BAD;
        @(negedge clk);
        check("t0_done_valid", rsp_valid0, 1);
        check("t0_done_rdata", rsp_rdata0, 16'h0BAD);
        check("t0_done_timeout", rsp_timeout0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
